// File: rtl/sum_reduce_pkg.sv
// Shared types and elaboration-time helpers for the parametrised sum reducer.
package sum_reduce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Result width that can hold the sum of n operands of w_in bits in either mode.
    function automatic int unsigned out_width(input int unsigned n, input int unsigned w_in);
        return (n <= 1) ? w_in : w_in + $clog2(n);
    endfunction

    // Number of reduction steps needed to take n live operands down to one.
    function automatic int unsigned reduce_steps(input int unsigned n, input int unsigned adders);
        int unsigned cnt;
        int unsigned steps;
        int unsigned k;
        cnt   = n;
        steps = 0;
        while (cnt > 1) begin
            k     = (cnt / 2 < adders) ? cnt / 2 : adders;
            cnt   = cnt - k;
            steps = steps + 1;
        end
        return steps;
    endfunction

endpackage

// File: rtl/sum_reduce_step.sv
// One combinational reduction step: pair up to ADDERS leading operands, compact the rest.
module sum_reduce_step
    import sum_reduce_pkg::*;
#(
    parameter int unsigned N      = 7,
    parameter int unsigned W_OUT  = 13,
    parameter int unsigned ADDERS = 2
) (
    input  logic [N-1:0][W_OUT-1:0] regs_i,
    input  logic [$clog2(N+1)-1:0]  count_i,
    output logic [N-1:0][W_OUT-1:0] regs_o,
    output logic [$clog2(N+1)-1:0]  count_o
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] half;
    logic [CW-1:0] k;

    always_comb begin
        half = count_i >> 1;
        k    = (int'(half) > int'(ADDERS)) ? CW'(ADDERS) : half;
    end

    assign count_o = count_i - k;

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [W_OUT-1:0] pair_sum;
        logic [W_OUT-1:0] shifted;

        if (2 * j + 1 < N) begin : g_pair
            assign pair_sum = regs_i[2*j] + regs_i[2*j+1];
        end else begin : g_nopair
            assign pair_sum = '0;
        end

        // Unpaired survivors slide down by k so operand order is preserved.
        always_comb begin
            shifted = regs_i[j];
            if (j + int'(k) < int'(N)) begin
                shifted = regs_i[IW'(j + int'(k))];
            end
        end

        assign regs_o[j] = (j < int'(k)) ? pair_sum : shifted;
    end

endmodule

// File: rtl/sum_reduce_n.sv
// Multi-cycle N-operand adder: load on r_enable, reduce with shared adders, hold result.
module sum_reduce_n
    import sum_reduce_pkg::*;
#(
    parameter  int unsigned N      = 7,
    parameter  int unsigned W_IN   = 10,
    parameter  int unsigned ADDERS = 2,
    localparam int unsigned W_OUT  = out_width(N, W_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_enable,
    input  logic              signed_mode,
    input  logic [N*W_IN-1:0] init_vals,
    output logic              busy,
    output logic              w_enable,
    output logic [W_OUT-1:0]  result
);

    localparam int unsigned CW    = $clog2(N + 1);
    localparam int unsigned STEPS = reduce_steps(N, ADDERS);

    state_e                   state_q, state_d;
    logic [N-1:0][W_OUT-1:0]  regs_q, regs_d, step_regs;
    logic [CW-1:0]            count_q, count_d, step_count;
    logic                     busy_q, busy_d;
    logic                     wen_q, wen_d;
    logic [W_OUT-1:0]         result_q, result_d;
    logic [CW-1:0]            reduce_cycles_q;

    sum_reduce_step #(
        .N      (N),
        .W_OUT  (W_OUT),
        .ADDERS (ADDERS)
    ) u_step (
        .regs_i  (regs_q),
        .count_i (count_q),
        .regs_o  (step_regs),
        .count_o (step_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            regs_q   <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            wen_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            wen_q    <= wen_d;
            result_q <= result_d;
        end
    end

    // A start always wins, aborting any reduction in flight.
    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        count_d  = count_q;
        busy_d   = busy_q;
        wen_d    = wen_q;
        result_d = result_q;
        if (r_enable) begin
            for (int i = 0; i < N; i++) begin
                regs_d[i] = signed_mode ? W_OUT'($signed(init_vals[i*W_IN +: W_IN]))
                                        : W_OUT'(init_vals[i*W_IN +: W_IN]);
            end
            count_d = CW'(N);
            state_d = REDUCE;
            busy_d  = 1'b1;
            wen_d   = 1'b0;
        end else begin
            case (state_q)
                REDUCE: begin
                    if (count_q > CW'(1)) begin
                        regs_d  = step_regs;
                        count_d = step_count;
                    end else begin
                        result_d = regs_q[0];
                        wen_d    = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_q;
    assign w_enable = wen_q;
    assign result   = result_q;

    // Edges spent in REDUCE since the last load; bounds the reduction length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reduce_cycles_q <= '0;
        end else if (state_q == REDUCE && !r_enable) begin
            reduce_cycles_q <= reduce_cycles_q + CW'(1);
        end else begin
            reduce_cycles_q <= '0;
        end
    end

    a_reduce_bounded: assert property (@(posedge clk) disable iff (rst)
        (state_q == REDUCE) |-> (reduce_cycles_q <= CW'(STEPS)));

endmodule

// File: tb/tb_sum_reduce_n.sv
// Randomised and directed checks of sum_reduce_n against an arithmetic reference model.
module tb_sum_reduce_n;

    localparam int LAT_A = 5;   // N=7, ADDERS=2
    localparam int LAT_B = 7;   // N=7, ADDERS=1
    localparam int LAT_C = 4;   // N=7, ADDERS=4

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en, sgn;
    logic [69:0] init;
    logic        busy_a, busy_b, busy_c, wen_a, wen_b, wen_c;
    logic [12:0] res_a, res_b, res_c;
    logic        r_en_d, sgn_d, busy_d, wen_d;
    logic [9:0]  init_d, res_d;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    sum_reduce_n #(.N(7), .W_IN(10), .ADDERS(2)) dut_a (
        .clk(clk), .rst(rst), .r_enable(r_en), .signed_mode(sgn), .init_vals(init),
        .busy(busy_a), .w_enable(wen_a), .result(res_a));
    sum_reduce_n #(.N(7), .W_IN(10), .ADDERS(1)) dut_b (
        .clk(clk), .rst(rst), .r_enable(r_en), .signed_mode(sgn), .init_vals(init),
        .busy(busy_b), .w_enable(wen_b), .result(res_b));
    sum_reduce_n #(.N(7), .W_IN(10), .ADDERS(4)) dut_c (
        .clk(clk), .rst(rst), .r_enable(r_en), .signed_mode(sgn), .init_vals(init),
        .busy(busy_c), .w_enable(wen_c), .result(res_c));
    sum_reduce_n #(.N(1), .W_IN(10), .ADDERS(2)) dut_d (
        .clk(clk), .rst(rst), .r_enable(r_en_d), .signed_mode(sgn_d), .init_vals(init_d),
        .busy(busy_d), .w_enable(wen_d), .result(res_d));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer sum of the seven operands, wrapped to 13 bits.
    function automatic logic [12:0] model_sum(input logic [69:0] v, input logic s);
        int acc;
        int x;
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            x = int'(v[i*10 +: 10]);
            if (s && x >= 512) x = x - 1024;
            acc = acc + x;
        end
        return 13'(acc);
    endfunction

    function automatic logic [69:0] fill(input int base, input int step);
        logic [69:0] v;
        for (int i = 0; i < 7; i++) v[i*10 +: 10] = 10'(base + step * i);
        return v;
    endfunction

    // Load edge, then scramble inputs so late changes would corrupt a non-sampling design.
    task automatic load(input logic [69:0] v, input logic s);
        r_en = 1'b1;
        init = v;
        sgn  = s;
        @(posedge clk); #1;
        r_en = 1'b0;
        init = 70'({$urandom(), $urandom(), $urandom()});
        sgn  = 1'($urandom_range(0, 1));
    endtask

    task automatic watch(input logic [69:0] v, input logic s, input int cycles);
        logic [12:0] exp_sum;
        exp_sum = model_sum(v, s);
        check("busy_at_load", 32'(busy_a), 32'(1));
        check("wen_at_load", 32'(wen_a), 32'(0));
        for (int e = 1; e <= cycles; e++) begin
            @(posedge clk); #1;
            check("wen_a", 32'(wen_a), 32'(e >= LAT_A));
            check("wen_b", 32'(wen_b), 32'(e >= LAT_B));
            check("wen_c", 32'(wen_c), 32'(e >= LAT_C));
            check("busy_a", 32'(busy_a), 32'(e < LAT_A));
            if (e >= LAT_A) check("res_a", 32'(res_a), 32'(exp_sum));
            if (e >= LAT_B) check("res_b", 32'(res_b), 32'(exp_sum));
            if (e >= LAT_C) check("res_c", 32'(res_c), 32'(exp_sum));
        end
    endtask

    // Asynchronous pulse between clock edges; outputs must clear with no edge.
    task automatic async_rst(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_busy"}, 32'(busy_a), 32'(0));
        check({tag, "_wen"}, 32'(wen_a), 32'(0));
        check({tag, "_res"}, 32'(res_a), 32'(0));
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [69:0] v;
        logic        s;
        rst    = 1'b1;
        r_en   = 1'b0;
        sgn    = 1'b0;
        init   = '0;
        r_en_d = 1'b0;
        sgn_d  = 1'b0;
        init_d = '0;
        #12;
        check("rst_busy", 32'(busy_a), 32'(0));
        check("rst_wen", 32'(wen_a), 32'(0));
        check("rst_res", 32'(res_a), 32'(0));
        check("rst_res_d", 32'(res_d), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        load(fill(1, 1), 1'b0);
        watch(fill(1, 1), 1'b0, 15);
        check("sum_1to7", 32'(res_a), 32'(13'h001C));

        load(fill(1023, 0), 1'b1);
        watch(fill(1023, 0), 1'b1, 8);
        check("signed_minus7", 32'(res_a), 32'(13'h1FF9));

        load(fill(1023, 0), 1'b0);
        watch(fill(1023, 0), 1'b0, 8);
        check("unsigned_7161", 32'(res_a), 32'(13'h1BF9));

        // Restart one edge into a reduction; the first job must never report.
        load(fill(1, 1), 1'b0);
        @(posedge clk); #1;
        check("restart_wen_e1", 32'(wen_a), 32'(0));
        load(fill(100, 0), 1'b0);
        watch(fill(100, 0), 1'b0, 8);
        check("restart_700", 32'(res_a), 32'(700));

        for (int t = 0; t < 10; t++) begin
            v = 70'({$urandom(), $urandom(), $urandom()});
            s = 1'($urandom_range(0, 1));
            load(v, s);
            watch(v, s, 8);
        end

        load(fill(3, 5), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        async_rst("rst_mid");
        v = 70'({$urandom(), $urandom(), $urandom()});
        load(v, 1'b1);
        watch(v, 1'b1, 9);
        async_rst("rst_done");
        load(fill(1, 1), 1'b1);
        watch(fill(1, 1), 1'b1, 8);

        // Single-operand configuration: one edge to done, bit pattern unchanged.
        for (int m = 0; m < 2; m++) begin
            r_en_d = 1'b1;
            init_d = 10'h2A5;
            sgn_d  = 1'(m);
            @(posedge clk); #1;
            r_en_d = 1'b0;
            init_d = 10'h000;
            check("n1_busy_load", 32'(busy_d), 32'(1));
            check("n1_wen_load", 32'(wen_d), 32'(0));
            @(posedge clk); #1;
            check("n1_wen", 32'(wen_d), 32'(1));
            check("n1_busy", 32'(busy_d), 32'(0));
            check("n1_res", 32'(res_d), 32'(10'h2A5));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
